// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin arbiter for one output port of a mesh router.
// Grants one requesting input at a time and holds the grant until its flit transfers.
// On a transfer it re-arbitrates in the same edge, so handover between requesters
// has no idle cycle.
// Optional build macro ARB_AGING_EN adds a per-requester wait counter. A requester
// that has waited MAX_WAIT cycles becomes urgent and wins before any non-urgent one.
module output_port_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int SEL_W    = $clog2(NUM_REQ),
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] arb_req;
  logic [SEL_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] pick_idle;
  logic [NUM_REQ-1:0] pick_xfer;
  logic               holder_req;

  // First set bit of r, searching circularly upward from index p.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
    logic [NUM_REQ-1:0] g;
    logic               found;
    logic [SEL_W-1:0]   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SEL_W'((int'(p) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Binary index of a one-hot vector (0 when empty).
  function automatic logic [SEL_W-1:0] encode(input logic [NUM_REQ-1:0] g);
    logic [SEL_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) e = e | SEL_W'(i);
    end
    return e;
  endfunction

`ifdef ARB_AGING_EN
  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [NUM_REQ-1:0] urgent;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
    logic [CNT_W-1:0] wait_q;

    // Count cycles spent requesting without the grant, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wait_q <= '0;
      end else if (!req[gi] || gnt_q[gi]) begin
        wait_q <= '0;
      end else if (wait_q != MAX_CNT) begin
        wait_q <= wait_q + 1'b1;
      end
    end

    assign urgent[gi] = req[gi] && (wait_q == MAX_CNT);
  end

  // Urgent requesters shadow everyone else; round-robin still orders them.
  assign arb_req = (|urgent) ? urgent : req;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_WAIT > 0);
  assign arb_req    = req;
`endif

  // After a transfer the pointer moves just past the winner, which becomes lowest priority.
  assign ptr_d      = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign pick_idle  = rr_pick(arb_req, ptr_q);
  assign pick_xfer  = rr_pick(arb_req, ptr_d);
  assign holder_req = |(req & gnt_q);

  // Grant FSM: IDLE arbitrates from ptr; GRANT holds until transfer or withdrawal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pick_idle) begin
            gnt_q   <= pick_idle;
            sel_q   <= encode(pick_idle);
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!holder_req) begin
            // Requester withdrew without transferring: release, keep ptr.
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (out_ready) begin
            ptr_q <= ptr_d;
            if (|pick_xfer) begin
              gnt_q   <= pick_xfer;
              sel_q   <= encode(pick_xfer);
              busy_q  <= 1'b1;
              state_q <= GRANT;
            end else begin
              gnt_q   <= '0;
              sel_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          gnt_q   <= '0;
          sel_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = holder_req;
  assign in_ready  = gnt_q & {NUM_REQ{out_ready}};

endmodule
